// File: rtl/fft_sm_unit_if.sv
// Handshake and display-path signals of the FFT controller.
interface fft_sm_unit_if;
    logic               Start;
    logic [7:0]         Inspect;
    logic signed [15:0] Result;
    logic               ActivateSSD;
    logic               Ready;
    logic               Done;

    modport master (
        output Start,
        output Inspect,
        input  Result,
        input  ActivateSSD,
        input  Ready,
        input  Done
    );

    modport slave (
        input  Start,
        input  Inspect,
        output Result,
        output ActivateSSD,
        output Ready,
        output Done
    );
endinterface

// File: rtl/fft_sm_unit.sv
// 16-point radix-2 DIT FFT over a fixed ROM waveform, computed in place,
// one butterfly per clock. The finished spectrum is held for the display.
//
// state | meaning
// IDLE  | waiting for Start, Ready=1
// LOAD  | 16 cycles, ROM copied into RAM in bit-reversed order
// CALC  | 32 cycles, 4 stages x 8 butterflies
// DONE  | spectrum frozen, Done=ActivateSSD=1, restart on a Start rising edge
module fft_sm_unit (
    input  logic          Clk,
    input  logic          Reset,
    fft_sm_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t             state;
    logic [4:0]         cnt;
    logic               start_q;
    logic               ready_r;
    logic               done_r;
    logic signed [15:0] ram_re [16];
    logic signed [15:0] ram_im [16];

    // ROM: alternating +64 / -64
    function automatic logic signed [7:0] rom_x(input logic [3:0] n);
        return n[0] ? -8'sd64 : 8'sd64;
    endfunction

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    // The down-counter runs 15..0 in LOAD and 31..0 in CALC; its complement
    // gives the up-counting load index / butterfly number.
    logic [3:0]         load_idx;
    logic [4:0]         bf;
    logic [1:0]         stg;
    logic [2:0]         j;
    logic [3:0]         p;
    logic [3:0]         q;
    logic [2:0]         tw;
    logic signed [15:0] wr;
    logic signed [15:0] wi;
    logic signed [7:0]  smp;

    assign load_idx = ~cnt[3:0];
    assign bf       = ~cnt;
    assign stg      = bf[4:3];
    assign j        = bf[2:0];
    assign smp      = rom_x(bitrev4(load_idx));

    // Butterfly addressing: top index p, partner p+h, twiddle index (p mod h)*(8/h)
    always_comb begin
        p  = 4'd0;
        tw = 3'd0;
        case (stg)
            2'd0: begin p = {j, 1'b0};                tw = 3'd0;             end
            2'd1: begin p = {j[2:1], 1'b0, j[0]};     tw = {j[0], 2'b00};    end
            2'd2: begin p = {j[2], 1'b0, j[1:0]};     tw = {j[1:0], 1'b0};   end
            default: begin p = {1'b0, j};             tw = j;                end
        endcase
        q = p | (4'd1 << stg);
    end

    // Twiddle constants W^k = cos - j*sin in Q2.14
    always_comb begin
        wr = 16'sd16384;
        wi = 16'sd0;
        case (tw)
            3'd0: begin wr =  16'sd16384; wi =  16'sd0;      end
            3'd1: begin wr =  16'sd15137; wi = -16'sd6270;   end
            3'd2: begin wr =  16'sd11585; wi = -16'sd11585;  end
            3'd3: begin wr =  16'sd6270;  wi = -16'sd15137;  end
            3'd4: begin wr =  16'sd0;     wi = -16'sd16384;  end
            3'd5: begin wr = -16'sd6270;  wi = -16'sd15137;  end
            3'd6: begin wr = -16'sd11585; wi = -16'sd11585;  end
            default: begin wr = -16'sd15137; wi = -16'sd6270; end
        endcase
    end

    logic signed [15:0] ar, ai, br, bi;
    logic signed [31:0] prr, pii, pri, pir;
    logic signed [31:0] sum_r, sum_i, sh_r, sh_i;
    logic signed [15:0] tr, ti;

    assign ar    = ram_re[p];
    assign ai    = ram_im[p];
    assign br    = ram_re[q];
    assign bi    = ram_im[q];
    assign prr   = wr * br;
    assign pii   = wi * bi;
    assign pri   = wr * bi;
    assign pir   = wi * br;
    // Round to nearest before dropping the 14 fraction bits
    assign sum_r = prr - pii + 32'sd8192;
    assign sum_i = pri + pir + 32'sd8192;
    assign sh_r  = sum_r >>> 14;
    assign sh_i  = sum_i >>> 14;
    assign tr    = sh_r[15:0];
    assign ti    = sh_i[15:0];

    // Sequencer with registered status outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            start_q <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            start_q <= bus.Start;
            case (state)
                IDLE: if (bus.Start) begin
                    state   <= LOAD;
                    cnt     <= 5'd15;
                    ready_r <= 1'b0;
                end
                LOAD: if (cnt == 5'd0) begin
                    state <= CALC;
                    cnt   <= 5'd31;
                end else begin
                    cnt <= cnt - 5'd1;
                end
                CALC: if (cnt == 5'd0) begin
                    state  <= DONE;
                    done_r <= 1'b1;
                end else begin
                    cnt <= cnt - 5'd1;
                end
                DONE: if (bus.Start && !start_q) begin
                    state  <= LOAD;
                    cnt    <= 5'd15;
                    done_r <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Working RAM: load in bit-reversed order, then in-place butterflies
    always_ff @(posedge Clk) begin
        if (state == LOAD) begin
            ram_re[load_idx] <= {{8{smp[7]}}, smp};
            ram_im[load_idx] <= 16'sd0;
        end else if (state == CALC) begin
            ram_re[p] <= ar + tr;
            ram_im[p] <= ai + ti;
            ram_re[q] <= ar - tr;
            ram_im[q] <= ai - ti;
        end
    end

    // Display outputs; Result is forced to zero outside DONE
    always_comb begin
        bus.Ready       = ready_r;
        bus.Done        = done_r;
        bus.ActivateSSD = done_r;
        bus.Result      = 16'sd0;
        if (done_r)
            bus.Result = bus.Inspect[4] ? ram_im[bus.Inspect[3:0]] : ram_re[bus.Inspect[3:0]];
    end

endmodule

// File: tb/tb_fft_sm_unit.sv
// Directed bench for fft_sm_unit. The ROM is an alternating +/-64 sequence,
// so the exact spectrum is X[8] = 16*64 = 1024 real, every other component 0.
module tb_fft_sm_unit;

    logic Clk;
    logic Reset;
    int   checks;
    int   passed;

    fft_sm_unit_if bus ();

    fft_sm_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  {31'd0, bus.Ready}, 1);
        chk({tag, "_done"},   {31'd0, bus.Done}, 0);
        chk({tag, "_ssd"},    {31'd0, bus.ActivateSSD}, 0);
        chk({tag, "_result"}, $signed(bus.Result), 0);
    endtask

    // Called right after edge E0 has been checked; verifies Done only at E0+48
    task automatic chk_latency(input string tag);
        for (int c = 1; c <= 47; c++) begin
            @(posedge Clk); #1;
            chk({tag, "_busy_done"}, {31'd0, bus.Done}, 0);
        end
        @(posedge Clk); #1;
        chk({tag, "_done_at_48"}, {31'd0, bus.Done}, 1);
        chk({tag, "_ssd_at_48"},  {31'd0, bus.ActivateSSD}, 1);
        chk({tag, "_ready_at_48"}, {31'd0, bus.Ready}, 0);
    endtask

    task automatic chk_spectrum(input string tag);
        @(negedge Clk); bus.Inspect = 8'h08; #1;
        chk({tag, "_re8"}, $signed(bus.Result), 1024);
        @(negedge Clk); bus.Inspect = 8'h18; #1;
        chk({tag, "_im8"}, $signed(bus.Result), 0);
        for (int i = 0; i < 32; i++) begin
            @(negedge Clk); bus.Inspect = 8'(i); #1;
            chk($sformatf("%s_bin%0d_%s", tag, i % 16, (i >= 16) ? "im" : "re"),
                $signed(bus.Result), (i == 8) ? 1024 : 0);
        end
        @(negedge Clk); bus.Inspect = 8'hE8; #1;
        chk({tag, "_hi_bits_ignored"}, $signed(bus.Result), 1024);
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        Reset       = 1'b0;
        bus.Start   = 1'b0;
        bus.Inspect = 8'h00;

        // Reset held for 5 cycles
        repeat (5) begin
            @(negedge Clk);
            chk_reset_outputs("in_reset");
        end

        // Release with Start held high
        Reset     = 1'b1;
        bus.Start = 1'b1;
        @(posedge Clk); #1;
        chk("run1_ready_fall", {31'd0, bus.Ready}, 0);
        chk_latency("run1");
        repeat (20) @(posedge Clk);
        #1;
        chk("run1_hold_done", {31'd0, bus.Done}, 1);
        chk_spectrum("run1");

        // Asynchronous reset while in DONE, then restart
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk_reset_outputs("reset_in_done");
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("run2_ready_fall", {31'd0, bus.Ready}, 0);
        repeat (19) @(posedge Clk);
        #1;
        chk("run2_mid_ready", {31'd0, bus.Ready}, 0);
        chk("run2_mid_done",  {31'd0, bus.Done}, 0);
        @(posedge Clk); #2;
        Reset = 1'b0;
        #1;
        chk_reset_outputs("reset_mid_run");
        @(negedge Clk);
        chk_reset_outputs("reset_mid_run_held");
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("run3_ready_fall", {31'd0, bus.Ready}, 0);
        chk_latency("run3");
        chk_spectrum("run3");

        // Start 1->0->1 in DONE restarts the computation
        @(negedge Clk); bus.Start = 1'b0;
        @(negedge Clk);
        chk("run4_low_still_done", {31'd0, bus.Done}, 1);
        bus.Start = 1'b1;
        @(posedge Clk); #1;
        chk("run4_done_drop", {31'd0, bus.Done}, 0);
        chk("run4_ready_low", {31'd0, bus.Ready}, 0);
        chk("run4_result_zero", $signed(bus.Result), 0);
        chk_latency("run4");
        repeat (10) @(posedge Clk);
        #1;
        chk("run4_hold_done", {31'd0, bus.Done}, 1);
        chk_spectrum("run4");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fft_sm_unit.md
# fft_sm_unit

Self-contained 16-point radix-2 decimation-in-time FFT controller and datapath for the tuner front end. On a start request it loads a fixed 16-sample test waveform from internal ROM and computes its spectrum in place. It then holds the result, one selectable bin component at a time, for the seven-segment display path. It sits between the top-level control/handshake logic and the display driver.

## Interface
- No parameters; all sizes are fixed: N=16, sample 8-bit signed, datapath 16-bit signed complex, twiddles Q2.14.
- Clk  input  1  sole clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset; forces the idle state immediately.
- Start  input  1  level request, sampled on Clk; acted on only in IDLE, or as a rising edge in DONE.
- Inspect  input  8  bin selector for Result.
  - [3:0] = bin index k.
  - [4] = 0 selects real part, 1 selects imaginary part.
  - [7:5] are ignored.
- Result  output  16  signed value of the selected component of X[k]; valid only while Done=1, 0 otherwise.
- ActivateSSD  output  1  display enable; equals Done.
- Ready  output  1  high exactly while in IDLE.
- Done  output  1  high exactly while in DONE.

## Operation
- ROM: x[n] = +64 for even n, −64 for odd n, n=0..15, 8-bit signed.
- Working RAM: 16 entries of {re, im}, each 16-bit signed.
- States and transitions:
  - IDLE: Ready=1. If Start=1, go to LOAD.
  - LOAD: 16 cycles. Cycle i writes RAM[i] = {sign-extend(x[bitrev4(i)]), 0}. Then go to CALC.
  - CALC: 32 cycles, one butterfly per cycle. Stages s=0..3, 8 butterflies each, in natural order.
    - Span h = 2^s; pair (p, p+h); twiddle index k = (p mod h)·(8/h).
    - Update: t = W^k·RAM[p+h]; RAM[p] ← RAM[p]+t; RAM[p+h] ← RAM[p]−t.
    - After the last butterfly, go to DONE.
  - DONE: Done=ActivateSSD=1; RAM frozen.
    - A Start rising edge (Start=0 at the previous edge, 1 now) goes to LOAD and recomputes.
    - If Start is held high continuously, the block stays in DONE.
- Twiddles W^k = cos(2πk/16) − j·sin(2πk/16), k=0..7.
  - cos values for k=0..4: 16384, 15137, 11585, 6270, 0. Values for k=5..7 follow by symmetry.
  - Stored as constants; no runtime generation.
- Complex multiply:
  - Four 16×16 signed products, 32-bit.
  - Each sum is rounded by adding 8192, then arithmetic-shifted right by 14, then truncated to 16 bits.
- Adds/subtracts are 16-bit two's complement with no scaling. No overflow is possible for this ROM; the maximum magnitude is 1024.
- Result mux is combinational from the Inspect bits and RAM[k]. RAM already holds natural-order output.

## Timing
- During and after reset:
  - state = IDLE, Ready=1, Done=0, ActivateSSD=0, Result=0.
  - RAM contents are don't-care.
- Start high at rising edge E0 in IDLE:
  - Ready falls after E0.
  - LOAD occupies E0+1..E0+16; CALC occupies E0+17..E0+48.
  - Done rises after edge E0+48 and remains high.
  - Latency is 48 clock cycles.
- Start is ignored in LOAD and CALC. Reset there aborts to IDLE asynchronously.
- Inspect changes in DONE propagate to Result combinationally, in the same cycle.
- Reset asserted mid-operation clears all outputs immediately. On release the block returns to IDLE; it resumes on the next edge where Start=1.

## Test plan
- Reset held low for 5 cycles → Ready=1, Done=0, ActivateSSD=0, Result=0 throughout.
- Release reset with Start=1 held forever → Ready drops after the next edge, and Done=ActivateSSD=1 exactly 48 cycles later. The block stays in DONE indefinitely.
- In DONE, Inspect=8'h08 → Result=1024. Inspect=8'h18 → Result=0.
- In DONE, sweep Inspect over k=0..15 with [4]=0 and [4]=1 → every component except real X[8] is within ±2 of 0. Inspect=8'hE8 → 1024, confirming bits [7:5] are ignored.
- Assert reset at cycle 20 after start → outputs reset immediately. After release with Start=1, the full 48-cycle run repeats and yields the same results.
- In DONE, drive Start 1→0→1 → LOAD restarts on the rising edge, Done drops, and Done returns 48 cycles later with identical results.
